// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the 16x16 bicolour LED matrix scanner.
package led_matrix_pkg;

    localparam int MATRIX_ROWS = 16;
    localparam int MATRIX_COLS = 16;

    typedef logic [MATRIX_COLS-1:0] pixel_row_t;
    typedef pixel_row_t [MATRIX_ROWS-1:0] pixel_frame_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    function automatic pixel_row_t row_onehot(input logic [3:0] row);
        return pixel_row_t'(1) << row;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// BLANK/DRIVE sequencer for one matrix row, with row-advance and frame-start strobes.
module led_scan_timer
    import led_matrix_pkg::*;
#(
    parameter int DRIVE_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        row_zero_i,
    output scan_state_t state_o,
    output logic        row_adv_o,
    output logic        frame_start_o
);

    localparam int MAXC  = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             row_adv;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BLANK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A dropped enable parks the sequencer at the start of a fresh BLANK interval.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        row_adv = 1'b0;
        if (!en_i) begin
            state_d = BLANK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end
                end
                DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        row_adv = 1'b1;
                    end
                end
                default: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign state_o       = state_q;
    assign row_adv_o     = row_adv;
    assign frame_start_o = en_i && (state_q == BLANK) && (cnt_q == '0) && row_zero_i;

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed scan driver for a 16x16 red/green LED matrix; all outputs registered.
// Optional build macro LED_SCAN_FRAMELATCH_EN latches the pixel arrays at each frame start.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int DRIVE_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         Enable,
    input  pixel_frame_t RedPixels,
    input  pixel_frame_t GrnPixels,
    output logic [15:0]  RowSelect,
    output logic [15:0]  RedDriver,
    output logic [15:0]  GrnDriver,
    output logic         FrameStart,
    output logic [3:0]   CurRow
);

    scan_state_t  scan_state;
    logic         row_adv;
    logic         frame_start;
    logic [3:0]   row_q, row_d;
    pixel_frame_t src_red, src_grn;

    pixel_row_t   row_sel_q, row_sel_d;
    pixel_row_t   red_q, red_d;
    pixel_row_t   grn_q, grn_d;
    logic         fs_q, fs_d;
    logic [3:0]   cur_row_q, cur_row_d;

    led_scan_timer #(
        .DRIVE_CYCLES(DRIVE_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk_i        (CLK),
        .rst_i        (RST),
        .en_i         (Enable),
        .row_zero_i   (row_q == 4'd0),
        .state_o      (scan_state),
        .row_adv_o    (row_adv),
        .frame_start_o(frame_start)
    );

`ifdef LED_SCAN_FRAMELATCH_EN
    pixel_frame_t red_shadow_q, grn_shadow_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            red_shadow_q <= '0;
            grn_shadow_q <= '0;
        end else if (frame_start) begin
            red_shadow_q <= RedPixels;
            grn_shadow_q <= GrnPixels;
        end
    end

    assign src_red = red_shadow_q;
    assign src_grn = grn_shadow_q;
`else
    assign src_red = RedPixels;
    assign src_grn = GrnPixels;
`endif

    assign row_d = row_q + {3'b000, row_adv};

    always_comb begin
        row_sel_d = '0;
        red_d     = '0;
        grn_d     = '0;
        fs_d      = frame_start;
        cur_row_d = row_q;
        if (Enable && (scan_state == DRIVE)) begin
            row_sel_d = row_onehot(row_q);
            red_d     = src_red[row_q];
            grn_d     = src_grn[row_q];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            row_q     <= '0;
            row_sel_q <= '0;
            red_q     <= '0;
            grn_q     <= '0;
            fs_q      <= 1'b0;
            cur_row_q <= '0;
        end else begin
            row_q     <= row_d;
            row_sel_q <= row_sel_d;
            red_q     <= red_d;
            grn_q     <= grn_d;
            fs_q      <= fs_d;
            cur_row_q <= cur_row_d;
        end
    end

    assign RowSelect  = row_sel_q;
    assign RedDriver  = red_q;
    assign GrnDriver  = grn_q;
    assign FrameStart = fs_q;
    assign CurRow     = cur_row_q;

endmodule
